// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Program memory plus load/run sequencer for the MIPS pipeline.
//             A program is streamed in one word per clock while i_write is
//             high. Loading closes on the HALT word or when memory is full.
//             The block then waits in READY for i_enable. In RUN it serves
//             registered, word-aligned fetches to the IF stage. It stops in
//             HALTED once HALT_CODE has been fetched.
//  Ports    : i_clk / i_reset      clock, asynchronous active-high reset
//             i_write/i_instruction load strobe and the word to load
//             i_enable / i_pc      run/advance strobe and byte fetch address
//             o_instruction        registered fetch result
//             o_ready              load closed, waiting for i_enable
//             o_halt               HALT fetched (sticky)
//             o_count              words loaded, HALT included
//             o_overflow           write attempted while memory full (sticky)
//  Options  : PROGRAM_LOADER_READBACK_EN adds i_dbg_addr / o_dbg_data.
//             This is a registered debug read port that works in every state.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int                 INST_SZ   = 32,
    parameter int                 PC_SZ     = 32,
    parameter int                 ADDR_SZ   = 10,
    parameter logic [INST_SZ-1:0] HALT_CODE = 32'h0000003F
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_write,
    input  logic [INST_SZ-1:0] i_instruction,
    input  logic               i_enable,
    input  logic [PC_SZ-1:0]   i_pc,
`ifdef PROGRAM_LOADER_READBACK_EN
    input  logic [ADDR_SZ-1:0] i_dbg_addr,
    output logic [INST_SZ-1:0] o_dbg_data,
`else
`endif
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_ready,
    output logic               o_halt,
    output logic [ADDR_SZ:0]   o_count,
    output logic               o_overflow
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_READY  = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Full-memory word count (2^ADDR_SZ), held one bit wider than an index
    localparam logic [ADDR_SZ:0] c_DEPTH = {1'b1, {ADDR_SZ{1'b0}}};

    state_t               r_state_q, w_state_d;
    logic [INST_SZ-1:0]   r_instr_q, w_instr_d;
    logic                 r_halt_q,  w_halt_d;
    logic                 r_ovf_q,   w_ovf_d;
    logic [ADDR_SZ:0]     r_count_q, w_count_d;

    logic [INST_SZ-1:0]   r_mem [0:(1<<ADDR_SZ)-1];

    logic                 w_mem_we;
    logic [ADDR_SZ:0]     w_count_inc;
    logic [ADDR_SZ-1:0]   w_fetch_idx;
    logic                 w_pc_hi_nz;
    logic                 w_in_range;
    logic [INST_SZ-1:0]   w_fetch_word;
    logic                 w_unused_pc_lsbs;

    // Fetches are word aligned, so the byte-offset bits carry no information
    assign w_unused_pc_lsbs = ^i_pc[1:0];

    // PC bits above the word index must be zero, otherwise the address lies
    // outside the memory and is treated as out of range
    generate
        if (PC_SZ > ADDR_SZ + 2) begin : g_pc_hi
            assign w_pc_hi_nz = |i_pc[PC_SZ-1:ADDR_SZ+2];
        end else begin : g_pc_no_hi
            assign w_pc_hi_nz = 1'b0;
        end
    endgenerate

    assign w_fetch_idx  = i_pc[ADDR_SZ+1:2];
    assign w_count_inc  = r_count_q + {{ADDR_SZ{1'b0}}, 1'b1};
    // Only words that were actually loaded are fetchable. Anything beyond
    // them reads as HALT, so a runaway PC ends execution cleanly.
    assign w_in_range   = !w_pc_hi_nz && ({1'b0, w_fetch_idx} < r_count_q);
    assign w_fetch_word = w_in_range ? r_mem[w_fetch_idx] : HALT_CODE;

    always_comb begin
        w_state_d = r_state_q;
        w_instr_d = r_instr_q;
        w_halt_d  = r_halt_q;
        w_ovf_d   = r_ovf_q;
        w_count_d = r_count_q;
        w_mem_we  = 1'b0;
        case (r_state_q)
            S_LOAD: begin
                // i_enable is deliberately not looked at while loading
                if (i_write) begin
                    w_mem_we  = 1'b1;
                    w_count_d = w_count_inc;
                    if ((i_instruction == HALT_CODE) || (w_count_inc == c_DEPTH)) begin
                        w_state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (i_enable) begin
                    w_state_d = S_RUN;
                end
                // Writes are never performed here; they only flag overflow
                // when the memory is already full
                if (i_write && (r_count_q == c_DEPTH)) begin
                    w_ovf_d = 1'b1;
                end
            end
            S_RUN: begin
                if (i_enable) begin
                    w_instr_d = w_fetch_word;
                    if (w_fetch_word == HALT_CODE) begin
                        w_state_d = S_HALTED;
                        w_halt_d  = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                w_state_d = S_HALTED;
            end
            default: begin
                w_state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state_q <= S_LOAD;
            r_instr_q <= '0;
            r_halt_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_instr_q <= w_instr_d;
            r_halt_q  <= w_halt_d;
            r_ovf_q   <= w_ovf_d;
            r_count_q <= w_count_d;
        end
    end

    // Program storage has no reset. The word count alone decides what is
    // valid.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_count_q[ADDR_SZ-1:0]] <= i_instruction;
        end
    end

`ifdef PROGRAM_LOADER_READBACK_EN
    logic [INST_SZ-1:0] r_dbg_data_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dbg_data_q <= '0;
        end else begin
            r_dbg_data_q <= r_mem[i_dbg_addr];
        end
    end

    assign o_dbg_data = r_dbg_data_q;
`else
`endif

    assign o_instruction = r_instr_q;
    assign o_ready       = (r_state_q == S_READY);
    assign o_halt        = r_halt_q;
    assign o_count       = r_count_q;
    assign o_overflow    = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. It drives a
//             full-depth instance and a 4-word instance in parallel with the
//             same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam logic [31:0] HALT = 32'h0000003F;
    localparam logic [31:0] LW   = 32'h8C030005;
    localparam logic [31:0] SW   = 32'hAC030005;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] ins;
    logic        en;
    logic [31:0] pc;

    logic [31:0] o_instr0, o_instr1;
    logic        o_ready0, o_ready1, o_halt0, o_halt1, o_ovf0, o_ovf1;
    logic [10:0] o_count0;
    logic [2:0]  o_count1;

`ifdef PROGRAM_LOADER_READBACK_EN
    logic [9:0]  dbg_addr0;
    logic [1:0]  dbg_addr1;
    logic [31:0] dbg_data0, dbg_data1;
`endif

    always #5 clk = ~clk;

    program_loader dut (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_instruction(ins),
        .i_enable(en), .i_pc(pc),
`ifdef PROGRAM_LOADER_READBACK_EN
        .i_dbg_addr(dbg_addr0), .o_dbg_data(dbg_data0),
`endif
        .o_instruction(o_instr0), .o_ready(o_ready0), .o_halt(o_halt0),
        .o_count(o_count0), .o_overflow(o_ovf0)
    );

    program_loader #(.ADDR_SZ(2)) dut_small (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_instruction(ins),
        .i_enable(en), .i_pc(pc),
`ifdef PROGRAM_LOADER_READBACK_EN
        .i_dbg_addr(dbg_addr1), .o_dbg_data(dbg_data1),
`endif
        .o_instruction(o_instr1), .o_ready(o_ready1), .o_halt(o_halt1),
        .o_count(o_count1), .o_overflow(o_ovf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (one slot per instance) -------------
    int          m_depth [2] = '{1024, 4};
    logic [31:0] m_mem   [2][1024];
    int          m_count [2];
    bit          m_closed[2], m_running[2], m_halted[2], m_ovf[2];
    logic [31:0] m_instr [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_closed[k] = 0; m_running[k] = 0;
            m_halted[k] = 0; m_ovf[k] = 0; m_instr[k] = 32'h0;
        end
    endtask

    task automatic model_step(input int k);
        logic [31:0] idx, v;
        if (m_halted[k]) begin
            // ignores everything
        end else if (m_running[k]) begin
            if (en) begin
                idx = pc >> 2;
                v = (idx < 32'(m_count[k])) ? m_mem[k][idx[9:0]] : HALT;
                m_instr[k] = v;
                if (v == HALT) m_halted[k] = 1;
            end
        end else if (m_closed[k]) begin
            if (en) m_running[k] = 1;
            if (wr && (m_count[k] == m_depth[k])) m_ovf[k] = 1;
        end else if (wr) begin
            m_mem[k][m_count[k]] = ins;
            m_count[k]++;
            if ((ins == HALT) || (m_count[k] == m_depth[k])) m_closed[k] = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_models();
        chk("instr0", o_instr0, m_instr[0]);
        chk("ready0", o_ready0, m_closed[0] && !m_running[0]);
        chk("halt0",  o_halt0,  m_halted[0]);
        chk("count0", o_count0, m_count[0]);
        chk("ovf0",   o_ovf0,   m_ovf[0]);
        chk("instr1", o_instr1, m_instr[1]);
        chk("ready1", o_ready1, m_closed[1] && !m_running[1]);
        chk("halt1",  o_halt1,  m_halted[1]);
        chk("count1", o_count1, m_count[1]);
        chk("ovf1",   o_ovf1,   m_ovf[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_models();
    endtask

    task automatic drive(input logic w, input logic [31:0] d, input logic e, input logic [31:0] p);
        wr = w; ins = d; en = e; pc = p;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_instr0"}, o_instr0, 0); chk({tag, "_ready0"}, o_ready0, 0);
        chk({tag, "_halt0"},  o_halt0,  0); chk({tag, "_count0"}, o_count0, 0);
        chk({tag, "_ovf0"},   o_ovf0,   0); chk({tag, "_instr1"}, o_instr1, 0);
        chk({tag, "_count1"}, o_count1, 0); chk({tag, "_ready1"}, o_ready1, 0);
    endtask

    // Reset is asserted between edges and checked before the next edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_zero("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0);
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b);
        drive(1, a, 0, 0);    step();
        drive(1, b, 0, 0);    step();
        drive(1, HALT, 0, 0); step();
        drive(0, 0, 1, 0);    step();   // READY -> RUN
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] ins;
        logic        en;
        logic [31:0] pc;
        logic [31:0] e_instr;
        logic        e_ready;
        logic        e_halt;
        int          e_count;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PROGRAM_LOADER_READBACK_EN
        dbg_addr0 = '0; dbg_addr1 = '0;
`endif
        // Test-plan load with enable high, then run PC 0,4,8
        tbl[0] = '{1'b1, LW,    1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b1, SW,    1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 2};
        tbl[2] = '{1'b1, HALT,  1'b1, 32'd0, 32'h0, 1'b1, 1'b0, 3};
        tbl[3] = '{1'b0, 32'h0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 3};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 3};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 32'd0, LW,    1'b0, 1'b0, 3};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 32'd4, SW,    1'b0, 1'b0, 3};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 32'd8, HALT,  1'b0, 1'b1, 3};
        tbl[8] = '{1'b1, LW,    1'b1, 32'd0, HALT,  1'b0, 1'b1, 3};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("init");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].wr, tbl[i].ins, tbl[i].en, tbl[i].pc);
            step();
            chk($sformatf("tbl%0d_instr", i), o_instr0, tbl[i].e_instr);
            chk($sformatf("tbl%0d_ready", i), o_ready0, tbl[i].e_ready);
            chk($sformatf("tbl%0d_halt", i),  o_halt0,  tbl[i].e_halt);
            chk($sformatf("tbl%0d_count", i), o_count0, tbl[i].e_count);
        end

        // Stall: o_instruction holds while enable is low, PC changing
        do_reset();
        load3(LW, SW);
        drive(0, 0, 1, 0); step();
        chk("stall_pre", o_instr0, LW);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'(4 + 4 * i)); step();
            chk("stall_hold", o_instr0, LW);
        end
        drive(0, 0, 1, 4); step();
        chk("stall_resume", o_instr0, SW);
`ifdef PROGRAM_LOADER_READBACK_EN
        dbg_addr0 = 10'd1; step();
        chk("dbg_rd", dbg_data0, SW);
        dbg_addr0 = '0;
`endif

        // Out of range fetch returns HALT
        do_reset();
        load3(32'h00221820, 32'h00432022);
        drive(0, 0, 1, 32'h40); step();
        chk("oor_instr", o_instr0, HALT);
        chk("oor_halt",  o_halt0,  1);

        // Small instance fills, then overflows on the fifth write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h20000000 + 32'(i), 0, 0); step();
        end
        chk("full_ready", o_ready1, 1);
        chk("full_count", o_count1, 4);
        chk("full_ovf",   o_ovf1,   1);

        // Reset mid-run, then reload a single HALT
        do_reset();
        load3(LW, SW);
        drive(0, 0, 1, 0); step();
        chk("run_before_rst", o_instr0, LW);
        do_reset();
        drive(1, HALT, 0, 0); step();
        chk("reload_count", o_count0, 1);
        chk("reload_ready", o_ready0, 1);

        // Randomised episodes against the model
        for (int e = 0; e < 8; e++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                wr  = (c < 8) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
                ins = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
                en  = ($urandom_range(0, 3) != 0);
                pc  = ($urandom_range(0, 9) == 0) ? $urandom
                      : 32'($urandom_range(0, 12) * 4 + $urandom_range(0, 3));
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
